// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic operation requests into 32-bit MIPS-Extended
// instruction words, buffers them in a small FIFO and streams them into
// instruction memory at consecutive word addresses.
module instr_encoder #(
  parameter int unsigned           DEPTH     = 4,
  parameter int unsigned           ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  output logic              err,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       count,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_BALRN = 4'd5,
    OP_JMADD = 4'd6,
    OP_LW    = 4'd7,
    OP_SW    = 4'd8,
    OP_BEQ   = 4'd9,
    OP_BMEM  = 4'd10,
    OP_JS    = 4'd11,
    OP_JZ    = 4'd12
  } op_e;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // R-type words carry a zero opcode and select the operation via funct.
  function automatic logic [31:0] r_word(input logic [4:0] rs, rt, rd,
                                         input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'h00, funct};
  endfunction

  // I-type words carry the opcode and a 16-bit immediate.
  function automatic logic [31:0] i_word(input logic [5:0] op,
                                         input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  enc_t                enc;
  logic [31:0]         mem [DEPTH];
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic                fifo_empty;
  logic                full;
  logic                accept;
  logic                push;
  logic                pop;
  logic                bad_op;

  // Translate the requested operation into its instruction word.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    enc.legal = 1'b1;
    enc.word  = '0;
    case (req_op)
      OP_ADD:   enc.word = r_word(req_rs, req_rt, req_rd, 6'h20);
      OP_SUB:   enc.word = r_word(req_rs, req_rt, req_rd, 6'h22);
      OP_AND:   enc.word = r_word(req_rs, req_rt, req_rd, 6'h24);
      OP_OR:    enc.word = r_word(req_rs, req_rt, req_rd, 6'h25);
      OP_SLT:   enc.word = r_word(req_rs, req_rt, req_rd, 6'h2A);
      OP_BALRN: enc.word = r_word(req_rs, req_rt, req_rd, 6'h16);
      OP_JMADD: enc.word = r_word(req_rs, req_rt, req_rd, 6'h2D);
      OP_LW:    enc.word = i_word(6'h23, req_rs, req_rt, req_imm);
      OP_SW:    enc.word = i_word(6'h2B, req_rs, req_rt, req_imm);
      OP_BEQ:   enc.word = i_word(6'h04, req_rs, req_rt, req_imm);
      OP_BMEM:  enc.word = i_word(6'h14, req_rs, req_rt, req_imm);
      OP_JS:    enc.word = i_word(6'h13, req_rs, req_rt, req_imm);
      OP_JZ:    enc.word = i_word(6'h1A, req_rs, req_rt, req_imm);
      default:  enc.legal = 1'b0;
    endcase
  end

  // Occupancy flags: the extra pointer bit separates full from empty when
  // the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // Handshakes; clear swallows any handshake in its cycle. req_ready has no
  // bypass from a simultaneous pop, so it depends on registered state only.
  assign req_ready = ~full;
  assign accept    = req_valid & req_ready & ~clear;
  assign push      = accept & enc.legal;
  assign bad_op    = accept & ~enc.legal;
  assign pop       = wr_valid & wr_ready & ~clear;

  assign wr_valid  = ~fifo_empty;
  assign empty     = fifo_empty;
  assign wr_data   = fifo_empty ? 32'h0 : mem[rd_ptr[PTR_W-1:0]];

  // FIFO storage: written on push, never read while empty.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; wr_data is forced
    // to zero while empty, so stale contents are never visible.
    if (push) mem[wr_ptr[PTR_W-1:0]] <= enc.word;
  end

  // Pointers, write address, word count and error pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= BASE_ADDR;
      count   <= '0;
      err     <= 1'b0;
    end else begin
      err <= bad_op;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        wr_addr <= wr_addr + ADDR_W'(4);
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed requests push hand-computed
// words into scoreboard queues; a monitor pops and compares on each write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;
  logic        wr_ready;

  logic        req_ready, err, wr_valid, empty;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] count;

  logic        s_req_ready, s_err, s_wr_valid, s_empty;
  logic [3:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [15:0] s_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q [$];
  logic [63:0] exp_sq [$];
  logic [31:0] exp_addr;
  logic [3:0]  exp_saddr;

  instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .err(err), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .count(count), .empty(empty)
  );

  instr_encoder #(.DEPTH(4), .ADDR_W(4), .BASE_ADDR(4'h0)) u_small (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(s_req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .err(s_err), .wr_valid(s_wr_valid), .wr_ready(wr_ready),
    .wr_addr(s_wr_addr), .wr_data(s_wr_data), .count(s_count), .empty(s_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every accepted write against the scoreboards.
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected none",
                   wr_addr, wr_data);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e[63:32]);
          check("wr_data", wr_data, e[31:0]);
        end
      end
      if (s_wr_valid && wr_ready) begin
        if (exp_sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_small_write: got addr %h data %h expected none",
                   s_wr_addr, s_wr_data);
        end else begin
          logic [63:0] e;
          e = exp_sq.pop_front();
          check("small_wr_addr", {28'h0, s_wr_addr}, e[63:32]);
          check("small_wr_data", s_wr_data, e[31:0]);
        end
      end
    end
  end

  function automatic void flush_model();
    exp_q.delete();
    exp_sq.delete();
    exp_addr  = 32'h0;
    exp_saddr = 4'h0;
  endfunction

  // Issue one request; called and returns at posedge+1.
  task automatic send(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                      input logic [15:0] imm, input logic legal,
                      input logic [31:0] word);
    bit done = 0;
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt;
    req_rd = rd; req_imm = imm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        done = 1;
        if (legal) begin
          exp_q.push_back({exp_addr, word});
          exp_sq.push_back({28'h0, exp_saddr, word});
          exp_addr  = exp_addr + 32'd4;
          exp_saddr = exp_saddr + 4'd4;
        end
        #1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL req_timeout: got no req_ready expected acceptance");
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Wait for both scoreboards to empty; returns at posedge+1.
  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_sq.size() == 0) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    flush_model();
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; req_valid = 1'b0; req_op = '0;
    req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0; wr_ready = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_err", err, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    @(posedge clk); #1;

    // add r3 = r1 + r2 with 1-cycle latency.
    wr_ready = 1'b1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h00221820);
    @(negedge clk);
    check("add_wr_valid", wr_valid, 1);
    @(posedge clk); #1;
    drain();
    @(negedge clk);
    check("add_count", count, 1);
    check("add_empty", empty, 1);
    @(posedge clk); #1;

    // lw then jz from a cleared address.
    do_clear();
    send(4'd7, 5'd29, 5'd8, 5'd0, 16'hFFFC, 1, 32'h8FA8FFFC);
    send(4'd12, 5'd4, 5'd0, 5'd0, 16'h0010, 1, 32'h68800010);
    drain();

    // Fill with writes stalled; the 5th request waits for space. The five
    // writes also wrap the 4-bit address of the small instance.
    do_clear();
    wr_ready = 1'b0;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h00221820);
    send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h00221822);
    send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h00221824);
    send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h00221825);
    @(negedge clk);
    check("full_req_ready", req_ready, 0);
    @(posedge clk); #1;
    wr_ready = 1'b1;
    @(negedge clk);
    check("no_bypass_req_ready", req_ready, 0);
    @(negedge clk);
    check("after_pop_req_ready", req_ready, 1);
    @(posedge clk); #1;
    send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0, 1, 32'h0022182A);
    drain();
    @(negedge clk);
    check("fill_count", count, 5);
    @(posedge clk); #1;

    // Illegal op: err pulse, no write, count unchanged.
    send(4'd14, 5'd1, 5'd2, 5'd3, 16'h1234, 0, 32'h0);
    @(negedge clk);
    check("illegal_err_pulse", err, 1);
    @(negedge clk);
    check("illegal_err_clear", err, 0);
    check("illegal_count", count, 5);
    check("illegal_empty", empty, 1);
    @(posedge clk); #1;

    // Remaining extended encodings.
    send(4'd8, 5'd2, 5'd3, 5'd0, 16'h0008, 1, 32'hAC430008);
    send(4'd9, 5'd1, 5'd2, 5'd9, 16'hFFFF, 1, 32'h1022FFFF);
    send(4'd10, 5'd3, 5'd4, 5'd0, 16'h0000, 1, 32'h50640000);
    send(4'd11, 5'd5, 5'd0, 5'd0, 16'h0001, 1, 32'h4CA00001);
    send(4'd6, 5'd5, 5'd6, 5'd7, 16'hFFFF, 1, 32'h00A6382D);
    send(4'd5, 5'd0, 5'd0, 5'd31, 16'h0, 1, 32'h0000F816);
    drain();

    // Clear with two buffered words and a concurrent request and write.
    wr_ready = 1'b0;
    send(4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 1, 32'h00210820);
    send(4'd1, 5'd2, 5'd2, 5'd2, 16'h0, 1, 32'h00421022);
    clear = 1'b1; req_valid = 1'b1; req_op = 4'd0; wr_ready = 1'b1;
    flush_model();
    @(posedge clk); #1;
    clear = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("clear_empty", empty, 1);
    check("clear_count", count, 0);
    check("clear_wr_addr", wr_addr, 0);
    check("clear_wr_valid", wr_valid, 0);
    @(posedge clk); #1;

    // Reset mid-stream discards buffered words.
    wr_ready = 1'b0;
    send(4'd2, 5'd3, 5'd3, 5'd3, 16'h0, 1, 32'h00631824);
    send(4'd3, 5'd4, 5'd4, 5'd4, 16'h0, 1, 32'h00842025);
    wr_ready = 1'b1;
    drain();
    send(4'd4, 5'd5, 5'd5, 5'd5, 16'h0, 1, 32'h00A5282A);
    wr_ready = 1'b0;
    send(4'd0, 5'd6, 5'd6, 5'd6, 16'h0, 1, 32'h00C63020);
    reset = 1'b1;
    flush_model();
    @(posedge clk); #1;
    reset = 1'b0;
    wr_ready = 1'b1;
    @(negedge clk);
    check("midrst_wr_valid", wr_valid, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_count", count, 0);
    check("midrst_req_ready", req_ready, 1);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Instruction encoder/loader, the inverse of the main control decoder: takes symbolic operation requests (op select, register numbers, immediate) and packs them into 32-bit MIPS-Extended instruction words.
- Encoded words are buffered in a small FIFO and streamed into instruction memory at consecutive word addresses.
- Used by the testbench/boot loader path to build programs in hardware, including the extended ops balrn, jmadd, bmem, js, jz.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 32, instruction-memory byte-address width
- BASE_ADDR, 0, byte address of the first word written after reset or clear

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous; flushes FIFO, reloads address to BASE_ADDR, zeroes count
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  4  operation select (table below)
- req_rs  in  5  rs field
- req_rt  in  5  rt field
- req_rd  in  5  rd field (R-type only)
- req_imm  in  16  immediate (I-type only)
- err  out  1  one-cycle pulse: illegal req_op was accepted and dropped
- wr_valid  out  1  imem write pending
- wr_ready  in  1  imem accepts write when wr_valid & wr_ready
- wr_addr  out  ADDR_W  byte address of current write
- wr_data  out  32  encoded instruction
- count  out  16  number of words written since reset/clear; saturates at 16'hFFFF
- empty  out  1  FIFO empty and no write pending

Behaviour:
- Op table (req_op → encoding):
  - 0 add: R, funct 0x20
  - 1 sub: R, funct 0x22
  - 2 and: R, funct 0x24
  - 3 or: R, funct 0x25
  - 4 slt: R, funct 0x2A
  - 5 balrn: R, funct 0x16
  - 6 jmadd: R, funct 0x2D
  - 7 lw: I, op 0x23
  - 8 sw: I, op 0x2B
  - 9 beq: I, op 0x04
  - 10 bmem: I, op 0x14
  - 11 js: I, op 0x13
  - 12 jz: I, op 0x1A
  - 13–15: illegal
- R format: {6'h00, rs, rt, rd, 5'h00, funct}.
- I format: {op, rs, rt, imm}. rd is ignored for I ops; rd and imm are ignored for illegal ops.
- req_ready = ~full. No bypass: when full, req_ready stays low even if a pop occurs in the same cycle.
- Accepting a legal op pushes the encoded word at that clock edge; wr_valid is high at the earliest on the next cycle (1-cycle latency).
- Accepting an illegal op pushes nothing; err is high for exactly the following cycle.
- wr_valid = FIFO non-empty. wr_data and wr_addr show the head entry and the current address, and hold stable while wr_valid & ~wr_ready.
- Pop on wr_valid & wr_ready. On pop: wr_addr += 4, wrapping modulo 2^ADDR_W; count += 1, saturating.
- Simultaneous push and pop in a non-full FIFO: both occur and occupancy is unchanged. Push into an empty FIFO is never presented on wr_data in the same cycle.
- Pointers wrap modulo DEPTH. Full is determined with an extra pointer bit.
- clear outranks push and pop in the same cycle: any request/write handshake in that cycle is discarded. Next cycle: FIFO empty, wr_addr = BASE_ADDR, count = 0.
- Reset values: req_ready=1, err=0, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, count=0, empty=1. Reset mid-stream discards all buffered words.
- empty = ~wr_valid.

Test Plan:
- Reset, then add with rs=1, rt=2, rd=3; wr_ready=1 → next cycle wr_data=32'h00221820, wr_addr=0; then count=1, empty=1.
- lw rs=29, rt=8, imm=16'hFFFC then jz rs=4, imm=0x0010 → writes 32'h8FA8FFFC at address 0, then 32'h68800010 at address 4.
- wr_ready=0 and push 5 legal ops with DEPTH=4 → 4 accepted, then req_ready=0. Raise wr_ready → words drain in order at addresses 0, 4, 8, 12, and req_ready returns the cycle after the first pop.
- req_op=14 → err pulses 1 cycle, nothing written, count unchanged.
- FIFO holding 2 entries, assert clear together with req_valid & wr_ready → next cycle empty=1, count=0, wr_addr=BASE_ADDR, no write issued.
- ADDR_W=4 with 5 writes → addresses 0, 4, 8, 12, then 0 (wrap); balrn rs=0, rt=0, rd=31 → 32'h0000F816.
